key_press_ctrl: RTL
===================

# key_press_ctrl

Keypad front-end for the alarm clock: debounces the raw keypad code, detects each new key press exactly once, and drives the one-cycle `shift` pulse and `key` value into the key shift register. It is the producer side of that shift interface. It also counts entered digits, flags a completed four-digit entry, and separates function keys (codes 10–15) from digits.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive identical samples required to accept a press or a release; legal range 2–255.
- `clock` input 1: single system clock, rising edge.
- `reset` input 1: synchronous, active-high reset.
- `key_in` input 4: raw keypad code; meaningful only while `key_valid` = 1.
- `key_valid` input 1: raw "key down" indication; may bounce.
- `clr_entry` input 1: synchronously clears the digit count.
- `shift` output 1: one-cycle pulse; the key register shifts in `key` on this cycle.
- `key` output 4: accepted key code; valid whenever `shift` or `func_key` is high, held otherwise.
- `func_key` output 1: one-cycle pulse for an accepted code 10–15.
- `digit_count` output 3: number of digits shifted since the last clear; saturates at 4.
- `entry_done` output 1: one-cycle pulse coincident with the 4th digit's `shift`.

## Operation
- FSM states and transitions:
  - IDLE → DEBOUNCE on `key_valid` = 1; latch `key_in` into the hold register; sample count = 1.
  - DEBOUNCE → IDLE if `key_valid` = 0 or `key_in` ≠ held code. Otherwise the sample count increments.
  - When the sample count reaches `DEBOUNCE_CYCLES`, go to PRESSED and issue the accept action.
  - PRESSED → RELEASE on `key_valid` = 0. A code change while the key is held is ignored.
  - RELEASE → PRESSED if `key_valid` returns to 1, with no new accept. After `DEBOUNCE_CYCLES` consecutive samples with `key_valid` = 0, go to IDLE.
- Accept action:
  - Held code 0–9: `shift` = 1 and `key` = code.
  - Held code 10–15: `func_key` = 1 and `key` = code; no shift and no count change.
- Exactly one accept occurs per physical press, however long the key is held.
- `digit_count` increments on every `shift` and saturates at 4. Shifting continues after saturation because the register keeps the last four keys.
- `entry_done` pulses only on the 3→4 transition of `digit_count`.
- `clr_entry` and `shift` in the same cycle: the clear applies first, then the shift counts, so `digit_count` = 1.
- `clr_entry` alone: `digit_count` = 0 on the next edge. It does not affect the FSM.

## Timing
- All outputs are registered.
- Reset values: `shift` 0, `func_key` 0, `entry_done` 0, `key` 0, `digit_count` 0, FSM in IDLE, sample count 0.
- Press latency:
  - First valid sample at edge N, stable through edge N+D−1 (D = `DEBOUNCE_CYCLES`).
  - The accept pulse is high from edge N+D−1 to edge N+D.
- `shift` and `func_key` are never high together and never high on consecutive cycles. The minimum spacing is 2·D cycles.
- A bounce in DEBOUNCE restarts qualification from IDLE; the next valid sample counts as sample 1.
- Reset mid-operation returns the FSM to IDLE and clears the counts. A key still held after reset is treated as a new press and is accepted again after D samples.

## Configuration
- `KEY_FUNC_EN` defined: codes 10–15 produce `func_key` as described above.
- `KEY_FUNC_EN` undefined:
  - All codes 0–15 produce `shift` and count as digits.
  - `func_key` is tied to 0.
  - The port list is unchanged.

## Structure
- Package `alarm_key_pkg` holds:
  - the FSM state enum (IDLE, DEBOUNCE, PRESSED, RELEASE);
  - `NUM_DIGITS` = 4;
  - `MAX_DIGIT_CODE` = 9;
  - the debounce counter width, $clog2(256).
- One natural sub-module, `key_stable_counter`: a loadable sample counter with clear and terminal-count flag. It is reused for both press and release qualification.

## Test plan
- Reset, then `key_valid` = 1 with `key_in` = 5 held for 10 cycles (D = 4) → a single `shift` 3 cycles after the first sample; `key` = 5; `digit_count` = 1.
- Press 1, 2, 3, 4, each held for 6 cycles with 6-cycle gaps → four `shift` pulses; `entry_done` with the 4th; `digit_count` = 4. Then press 7 → `shift` fires, `digit_count` stays 4, no `entry_done`.
- `key_in` = 8 with `key_valid` toggling 1,1,0,1,1,1,1 → exactly one `shift`, on the 4th consecutive high sample; a release glitch of 2 low cycles while PRESSED produces no second `shift`.
- Code 12 held for 8 cycles → `func_key` pulse with `key` = 12, no `shift`, `digit_count` unchanged. With `KEY_FUNC_EN` undefined → `shift` with `key` = 12 and the count increments.
- `clr_entry` asserted in the same cycle as a `shift` while `digit_count` = 3 → `digit_count` = 1 and no `entry_done`.
- `reset` asserted during PRESSED while the key is held → outputs go to 0 at the next edge; after reset is released, a new `shift` fires after D samples.

Source files
------------

// File: rtl/alarm_key_pkg.sv
// Shared types and constants for the alarm-clock keypad front-end.
// Optional function-key support is selected in key_press_ctrl with KEY_FUNC_EN.
package alarm_key_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2,
        RELEASE  = 2'd3
    } key_state_e;

    localparam logic [2:0] NUM_DIGITS     = 3'd4;
    localparam logic [3:0] MAX_DIGIT_CODE = 4'd9;
    localparam int         CNT_W          = $clog2(256);

    // Digit count saturates once a full entry is on the display.
    function automatic logic [2:0] sat_inc_digits(input logic [2:0] cnt);
        logic [2:0] nxt;
        if (cnt >= NUM_DIGITS) begin
            nxt = NUM_DIGITS;
        end else begin
            nxt = cnt + 3'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/key_stable_counter.sv
// Loadable sample counter used to qualify both key presses and key releases.
// tc_o flags that the next qualifying sample is the TERMINAL-th one.
module key_stable_counter #(
    parameter int WIDTH    = 8,
    parameter int TERMINAL = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic clr_i,
    input  logic load_i,
    input  logic inc_i,
    output logic tc_o
);

    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] LAST = WIDTH'(TERMINAL - 1);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // Load marks the first sample; increment counts further matching samples.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = ONE;
        end else if (inc_i) begin
            cnt_d = cnt_q + ONE;
        end else if (clr_i) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Sample count register.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == LAST);

endmodule

// File: rtl/key_press_ctrl.sv
// Keypad front-end: debounces key codes, accepts each press once, drives shift/key.
// Define KEY_FUNC_EN to split codes 10-15 out as func_key pulses instead of digits.
import alarm_key_pkg::*;

module key_press_ctrl #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] key_in,
    input  logic       key_valid,
    input  logic       clr_entry,
    output logic       shift,
    output logic [3:0] key,
    output logic       func_key,
    output logic [2:0] digit_count,
    output logic       entry_done
);

    key_state_e state_q;
    logic [3:0] hold_q;
    logic [3:0] key_q;
    logic       shift_q;
    logic       func_key_q;
    logic       entry_done_q;
    logic [2:0] digit_count_q;

    logic       cnt_load_s;
    logic       cnt_inc_s;
    logic       cnt_clr_s;
    logic       cnt_tc_s;
    logic       key_match_s;
    logic       is_func_s;
    logic [2:0] digit_base_s;

    key_stable_counter #(
        .WIDTH    (CNT_W),
        .TERMINAL (DEBOUNCE_CYCLES)
    ) u_stable_cnt (
        .clock  (clock),
        .reset  (reset),
        .clr_i  (cnt_clr_s),
        .load_i (cnt_load_s),
        .inc_i  (cnt_inc_s),
        .tc_o   (cnt_tc_s)
    );

    // Counter runs only while qualifying a press or a release; otherwise it is held at zero.
    always_comb begin
        cnt_load_s  = 1'b0;
        cnt_inc_s   = 1'b0;
        key_match_s = key_valid && (key_in == hold_q);
        case (state_q)
            IDLE:     cnt_load_s = key_valid;
            DEBOUNCE: cnt_inc_s  = key_match_s && !cnt_tc_s;
            PRESSED:  cnt_load_s = !key_valid;
            RELEASE:  cnt_inc_s  = !key_valid && !cnt_tc_s;
            default:  cnt_load_s = 1'b0;
        endcase
        cnt_clr_s = !(cnt_load_s || cnt_inc_s);
    end

    // Clear applies before a coincident shift is counted.
    always_comb begin
        if (clr_entry) begin
            digit_base_s = 3'd0;
        end else begin
            digit_base_s = digit_count_q;
        end
`ifdef KEY_FUNC_EN
        is_func_s = (hold_q > MAX_DIGIT_CODE);
`else
        is_func_s = 1'b0;
`endif
    end

    // Press/release FSM with registered accept outputs and digit bookkeeping.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            hold_q        <= 4'd0;
            key_q         <= 4'd0;
            shift_q       <= 1'b0;
            func_key_q    <= 1'b0;
            entry_done_q  <= 1'b0;
            digit_count_q <= 3'd0;
        end else begin
            shift_q       <= 1'b0;
            func_key_q    <= 1'b0;
            entry_done_q  <= 1'b0;
            digit_count_q <= digit_base_s;
            case (state_q)
                IDLE: begin
                    if (key_valid) begin
                        hold_q  <= key_in;
                        state_q <= DEBOUNCE;
                    end
                end
                DEBOUNCE: begin
                    if (!key_match_s) begin
                        state_q <= IDLE;
                    end else if (cnt_tc_s) begin
                        state_q <= PRESSED;
                        key_q   <= hold_q;
                        if (is_func_s) begin
                            func_key_q <= 1'b1;
                        end else begin
                            shift_q       <= 1'b1;
                            digit_count_q <= sat_inc_digits(digit_base_s);
                            entry_done_q  <= (digit_base_s == (NUM_DIGITS - 3'd1));
                        end
                    end
                end
                PRESSED: begin
                    if (!key_valid) begin
                        state_q <= RELEASE;
                    end
                end
                RELEASE: begin
                    if (key_valid) begin
                        state_q <= PRESSED;
                    end else if (cnt_tc_s) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign shift       = shift_q;
    assign key         = key_q;
    assign func_key    = func_key_q;
    assign digit_count = digit_count_q;
    assign entry_done  = entry_done_q;

endmodule
